// File: rtl/aes_key_mem.sv
// -----------------------------------------------------------------------------
// aes_key_mem
//
// AES key expansion and round-key storage. On init the cipher key is expanded
// into 11 (AES-128) or 15 (AES-256) round keys, one key per clock, and kept in
// a register file that the round blocks read combinationally by index.
// While busy the block borrows the shared 32-bit S-box.
//
// Ports:
//   clk        in   1    clock
//   reset_n    in   1    asynchronous active-low reset
//   key        in   256  cipher key; AES-128 uses key[255:128]
//   keylen     in   1    0 = AES-128, 1 = AES-256; sampled when init is taken
//   init       in   1    start expansion (pulse or level, honoured only in idle)
//   round      in   4    round-key index for read-out
//   round_key  out  128  stored key selected by round (index 15 reads 0)
//   ready      out  1    1 = idle, stored keys valid
//   sboxw      out  32   word sent to the shared S-box
//   new_sboxw  in   32   S-box substitution of sboxw, same cycle
// -----------------------------------------------------------------------------
module aes_key_mem #(
  parameter logic [3:0] AES128_ROUNDS = 4'ha,
  parameter logic [3:0] AES256_ROUNDS = 4'he
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [255:0] key,
  input  logic         keylen,
  input  logic         init,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         ready,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_GENERATE,
    ST_DONE
  } state_t;

  state_t       state, state_next;

  logic [127:0] key_mem [0:14];
  logic [127:0] prev_key0;   // key two rounds back (AES-256 only)
  logic [127:0] prev_key1;   // most recently generated key
  logic [3:0]   round_ctr;
  logic [7:0]   rcon;
  logic         keylen_reg;

  logic [3:0]   num_rounds;
  logic         use_rcon;
  logic [127:0] w;
  logic [31:0]  t, n0, n1, n2, n3;
  logic [127:0] new_key;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
  endfunction

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state logic. init is only looked at in idle, so a held init or a
  // toggling keylen cannot restart an expansion in flight.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_next = state;
    case (state)
      ST_IDLE:     if (init) state_next = ST_INIT;
      ST_INIT:     state_next = ST_GENERATE;
      ST_GENERATE: if (round_ctr == num_rounds) state_next = ST_DONE;
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // One round key per cycle. The S-box always sees the last word of the
  // newest key; AES-256 odd rounds use SubWord without RotWord/rcon.
  always_comb begin
    num_rounds = keylen_reg ? AES256_ROUNDS : AES128_ROUNDS;
    use_rcon   = !keylen_reg || !round_ctr[0];
    w          = keylen_reg ? prev_key0 : prev_key1;
    t          = use_rcon ? ({new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon, 24'h0})
                          : new_sboxw;
    n0         = w[127:96] ^ t;
    n1         = w[95:64]  ^ n0;
    n2         = w[63:32]  ^ n1;
    n3         = w[31:0]   ^ n2;
    new_key    = {n0, n1, n2, n3};
  end

  assign sboxw = prev_key1[31:0];

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the key file is cleared on reset so no stale key material
      // survives a reset; this makes it flops rather than a RAM macro.
      for (int i = 0; i < 15; i++) key_mem[i] <= '0;
      prev_key0  <= '0;
      prev_key1  <= '0;
      round_ctr  <= '0;
      rcon       <= 8'h01;
      keylen_reg <= 1'b0;
      ready      <= 1'b1;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      case (state)
        ST_IDLE: begin
          if (init) begin
            keylen_reg <= keylen;
            ready      <= 1'b0;
          end
        end
        ST_INIT: begin
          key_mem[0] <= key[255:128];
          rcon       <= 8'h01;
          if (keylen_reg) begin
            key_mem[1] <= key[127:0];
            prev_key0  <= key[255:128];
            prev_key1  <= key[127:0];
            round_ctr  <= 4'd2;
          end else begin
            prev_key1  <= key[255:128];
            round_ctr  <= 4'd1;
          end
        end
        ST_GENERATE: begin
          key_mem[round_ctr] <= new_key;
          prev_key0          <= prev_key1;
          prev_key1          <= new_key;
          round_ctr          <= round_ctr + 4'd1;
          if (use_rcon) rcon <= xtime(rcon);
        end
        ST_DONE: begin
          ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Combinational read-out; index 15 has no storage behind it and reads 0.
  always_comb begin
    round_key = '0;
    if (round != 4'hf) round_key = key_mem[round];
  end

endmodule
